// File: rtl/act_pkg.sv
// Shared definitions for the activation stage: activation modes and FSM state encodings.
// No logic and no latency.
// No flow control.
package act_pkg;

  // Activation modes. The encoding matches the 2-bit mode input.
  typedef enum logic [1:0] {
    ACT_RELU  = 2'b00,
    ACT_LEAKY = 2'b01,
    ACT_RELU6 = 2'b10,
    ACT_PASS  = 2'b11
  } act_mode_e;

  // Vector-pass sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/act_lane.sv
// Single-element activation function (ReLU / leaky / ReLU6 / pass) on a signed fixed-point value.
// Purely combinational; zero cycles.
// No flow control.
//
// Ports:
//   x    : signed DATA_WIDTH-bit input element, FRAC_BITS fractional bits
//   mode : activation selector
//   y    : result, same format as x
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_mode_e                    mode,
  output logic signed [DATA_WIDTH-1:0] y
);

  // 6.0 in the element's fixed-point format. It always fits because the top
  // level limits FRAC_BITS to DATA_WIDTH-4.
  localparam logic signed [DATA_WIDTH-1:0] SIX = DATA_WIDTH'(6 << FRAC_BITS);

  logic neg;
  assign neg = x[DATA_WIDTH-1];

  always_comb begin
    y = x;
    case (mode)
      ACT_RELU:  if (neg) y = '0;
      // The arithmetic shift rounds toward -inf. For example, -1 LSB stays -1 LSB.
      ACT_LEAKY: if (neg) y = x >>> LEAKY_SHIFT;
      ACT_RELU6: begin
        if (neg)          y = '0;
        else if (x > SIX) y = SIX;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Multi-mode activation stage: snapshots a signed vector and applies the selected activation LANES elements per cycle.
// Latency from start to done is WIDTH/LANES + 1 cycles. done is a one-cycle pulse.
// There is no backpressure: start is accepted only in IDLE, and a start in RUN/DONE is dropped. abort cancels a pass.
//
// Ports:
//   clk, reset_n  : clock (rising edge), async active-low reset
//   start         : begin a pass (sampled in IDLE only)
//   mode          : 00 ReLU, 01 leaky, 10 ReLU6, 11 pass
//   abort         : synchronous cancel while running; no done is produced
//   input_vector  : WIDTH elements, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   output_vector : results, same packing; changes only on RUN writes
//   busy          : high while in RUN
//   done          : one-cycle pulse when the full vector has been written
module activation_unit
  import act_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic                        abort,
  input  logic [WIDTH*DATA_WIDTH-1:0] input_vector,
  output logic [WIDTH*DATA_WIDTH-1:0] output_vector,
  output logic                        busy,
  output logic                        done
);

  localparam int NGROUPS  = WIDTH / LANES;
  localparam int GRP_BITS = LANES * DATA_WIDTH;
  localparam int GW       = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGROUPS - 1);

  if (WIDTH % LANES != 0) begin : g_chk_lanes
    $error("activation_unit: WIDTH must be a multiple of LANES");
  end
  if (FRAC_BITS + 3 > DATA_WIDTH - 1) begin : g_chk_frac
    $error("activation_unit: FRAC_BITS too large to represent 6.0");
  end

  state_e                      state, state_nxt;
  logic [GW-1:0]               grp;        // group index; element index = grp*LANES
  logic [WIDTH*DATA_WIDTH-1:0] cap_vec;
  act_mode_e                   cap_mode;
  logic                        wr_en;
  logic [GRP_BITS-1:0]         grp_x;
  logic [GRP_BITS-1:0]         grp_y;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        // abort wins over both the write and the final-group transition.
        // A group being processed in the abort cycle is therefore never written.
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          wr_en = 1'b1;
          if (grp == LAST_GRP) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ snapshot + output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grp           <= '0;
      cap_vec       <= '0;
      cap_mode      <= ACT_RELU;
      output_vector <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cap_vec  <= input_vector;
        cap_mode <= act_mode_e'(mode);
        grp      <= '0;
      end
      if (wr_en) begin
        output_vector[int'(grp)*GRP_BITS +: GRP_BITS] <= grp_y;
        grp <= grp + 1'b1;
      end
    end
  end

  assign grp_x = cap_vec[int'(grp)*GRP_BITS +: GRP_BITS];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    act_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FRAC_BITS   (FRAC_BITS),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .x    (grp_x[l*DATA_WIDTH +: DATA_WIDTH]),
      .mode (cap_mode),
      .y    (grp_y[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit (Q8.8, WIDTH=128).
// Runs a LANES=4 main instance, plus LANES=1 and LANES=8 instances for the latency checks.
module tb_activation_unit;
  import act_pkg::*;

  localparam int W  = 128;
  localparam int DW = 16;
  localparam int VB = W * DW;
  typedef logic [VB-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset_n, start, start_x, abort, abort_x;
  logic [1:0] mode;
  vec_t       input_vector;
  vec_t       out4, out1, out8;
  logic       busy4, done4, busy1, done1, busy8, done8;

  int n_vec = 0;
  int n_bad = 0;
  int l1_at, l8_at;

  always #5 clk = ~clk;

  activation_unit #(.WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(4), .LEAKY_SHIFT(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .abort(abort),
    .input_vector(input_vector), .output_vector(out4), .busy(busy4), .done(done4));

  activation_unit #(.WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(1), .LEAKY_SHIFT(3)) u_l1 (
    .clk(clk), .reset_n(reset_n), .start(start_x), .mode(mode), .abort(abort_x),
    .input_vector(input_vector), .output_vector(out1), .busy(busy1), .done(done1));

  activation_unit #(.WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(8), .LEAKY_SHIFT(3)) u_l8 (
    .clk(clk), .reset_n(reset_n), .start(start_x), .mode(mode), .abort(abort_x),
    .input_vector(input_vector), .output_vector(out8), .busy(busy8), .done(done8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic vec_t fill4(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
    logic [15:0] t [4];
    vec_t f;
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    for (int i = 0; i < W; i++) f[i*DW +: DW] = t[i % 4];
    return f;
  endfunction

  task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
    for (int i = 0; i < W; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got[i*DW +: DW]), 32'(exp[i*DW +: DW]));
  endtask

  // Starts a pass on the main instance (and on the side instances if aux=1).
  // It then observes nobs negedges.
  // abort_at/disturb_at select the observation at which abort is raised, or at
  // which inputs are scrambled and start is re-pulsed. A value of 0 means never.
  task automatic run_pass(input logic [1:0] m, input vec_t v, input logic aux,
                          input int abort_at, input int disturb_at, input int nobs,
                          output int done_at, output int busy_cyc, output int done_cnt,
                          output int busy_ab);
    @(negedge clk);
    mode = m; input_vector = v; start = 1'b1; start_x = aux; abort = 1'b0;
    done_at = -1; busy_cyc = 0; done_cnt = 0; busy_ab = -1;
    l1_at = -1; l8_at = -1;
    for (int k = 1; k <= nobs; k++) begin
      @(negedge clk);
      start = 1'b0; start_x = 1'b0; abort = 1'b0;
      if (busy4) busy_cyc++;
      if (done4) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done1 && l1_at < 0) l1_at = k;
      if (done8 && l8_at < 0) l8_at = k;
      if (abort_at != 0 && k == abort_at + 1) busy_ab = int'(busy4);
      if (k == abort_at) abort = 1'b1;
      if (k == disturb_at) begin
        input_vector = ~v;
        mode         = ~m;
        start        = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t va, ve, vb;
    int   d_at, b_cyc, d_cnt, b_ab, dn;

    reset_n = 1'b0; start = 1'b0; start_x = 1'b0; abort = 1'b0; abort_x = 1'b0;
    mode = 2'b00; input_vector = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_out_nonzero", 32'(out4 != '0), 0);
    reset_n = 1'b1;

    // ReLU with alternating +1.5 / -1.5 elements, on all three lane widths.
    va = fill4(16'h0180, 16'hFE80, 16'h0180, 16'hFE80);
    ve = fill4(16'h0180, 16'h0000, 16'h0180, 16'h0000);
    run_pass(ACT_RELU, va, 1'b1, 0, 0, 140, d_at, b_cyc, d_cnt, b_ab);
    chk("relu_done_at", d_at, 33);
    chk("relu_busy_cycles", b_cyc, 32);
    chk("relu_done_count", d_cnt, 1);
    check_vec("relu_out", out4, ve);
    chk("l1_done_at", l1_at, 129);
    chk("l8_done_at", l8_at, 17);
    check_vec("l1_out", out1, ve);
    check_vec("l8_out", out8, ve);

    // Leaky ReLU.
    va = fill4(16'hFF00, 16'hFFFF, 16'h0200, 16'h8000);
    ve = fill4(16'hFFE0, 16'hFFFF, 16'h0200, 16'hF000);
    run_pass(ACT_LEAKY, va, 1'b0, 0, 0, 40, d_at, b_cyc, d_cnt, b_ab);
    chk("leaky_done_at", d_at, 33);
    check_vec("leaky_out", out4, ve);

    // ReLU6 boundaries.
    va = fill4(16'h0700, 16'h0600, 16'h05FF, 16'h8000);
    ve = fill4(16'h0600, 16'h0600, 16'h05FF, 16'h0000);
    run_pass(ACT_RELU6, va, 1'b0, 0, 0, 40, d_at, b_cyc, d_cnt, b_ab);
    chk("relu6_done_at", d_at, 33);
    check_vec("relu6_out", out4, ve);

    // Snapshot: inputs and mode are scrambled and start is re-pulsed mid-run.
    for (int i = 0; i < W; i++) va[i*DW +: DW] = 16'hC000 + 16'(i * 16'h0123);
    run_pass(ACT_PASS, va, 1'b0, 0, 5, 80, d_at, b_cyc, d_cnt, b_ab);
    chk("snap_done_at", d_at, 33);
    chk("snap_done_count", d_cnt, 1);
    chk("snap_busy_cycles", b_cyc, 32);
    check_vec("snap_out", out4, va);

    // Abort at RUN cycle 10: groups 0..9 get new values, the rest keep pass values.
    vb = fill4(16'h0700, 16'h0700, 16'h0700, 16'h0700);
    for (int i = 0; i < W; i++) ve[i*DW +: DW] = (i < 40) ? 16'h0600 : va[i*DW +: DW];
    run_pass(ACT_RELU6, vb, 1'b0, 11, 0, 50, d_at, b_cyc, d_cnt, b_ab);
    chk("abort_done_count", d_cnt, 0);
    chk("abort_busy_cycles", b_cyc, 11);
    chk("abort_busy_after", b_ab, 0);
    check_vec("abort_out", out4, ve);
    run_pass(ACT_RELU, vb, 1'b0, 0, 0, 40, d_at, b_cyc, d_cnt, b_ab);
    chk("post_abort_done_at", d_at, 33);
    check_vec("post_abort_out", out4, vb);

    // Async reset in the middle of a pass.
    @(negedge clk);
    mode = ACT_PASS; input_vector = fill4(16'h1234, 16'h1234, 16'h1234, 16'h1234); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("prerst_busy", 32'(busy4), 1);
    chk("prerst_out_nonzero", 32'(out4 != '0), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_nonzero", 32'(out4 != '0), 0);
    chk("midrst_busy", 32'(busy4), 0);
    chk("midrst_done", 32'(done4), 0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk("postrst_done_count", dn, 0);
    chk("postrst_out_nonzero", 32'(out4 != '0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
